// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and default width.
// Encodings line up with the divider's Idle/Starting/Load so one sequencer monitor decodes both.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STARTING = 3'd1,
    LOAD     = 3'd2,
    ADD      = 3'd3,
    SHIFT    = 3'd4
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Issue/result bundle shared by the arithmetic units and their sequencer.
interface shift_add_multiplier_if #(
  parameter int N = 8
);

  // Handshake: READY=1 means idle and product holds the last result. The sequencer
  // raises START (level) and an operation launches when START falls again; operands
  // must be stable on that falling edge. START while READY=0 is ignored.
  logic           START;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           READY;

  modport master (
    output START,
    output multiplicand,
    output multiplier,
    input  product,
    input  READY
  );

  modport slave (
    input  START,
    input  multiplicand,
    input  multiplier,
    output product,
    output READY
  );

endinterface

// File: rtl/shift_add_multiplier_controller.sv
// Sequencing FSM for the shift-add multiplier: release-to-launch start, then N ADD/SHIFT pairs.
module shift_add_multiplier_controller
  import shift_add_multiplier_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   count_co,
  input  logic   q0,
  output logic   ld_m,
  output logic   ld_q,
  output logic   init_a,
  output logic   init_count,
  output logic   ld_add,
  output logic   ld_shift,
  output logic   count_en,
  output logic   ready,
  output state_t state
);

  function automatic state_t next_of(state_t s, logic go, logic co);
    case (s)
      IDLE:     return go ? STARTING : IDLE;
      STARTING: return go ? STARTING : LOAD;
      LOAD:     return ADD;
      ADD:      return SHIFT;
      SHIFT:    return co ? IDLE : ADD;
      default:  return IDLE;
    endcase
  endfunction

  state_t next_state;
  logic   load_q;
  logic   add_q;
  logic   shift_q;

  assign next_state = next_of(state, start, count_co);

  // Strobes are registered from the next state so each is high exactly while its state is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      load_q  <= 1'b0;
      add_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state   <= next_state;
      load_q  <= (next_state == LOAD);
      add_q   <= (next_state == ADD);
      shift_q <= (next_state == SHIFT);
    end
  end

  assign ld_m       = load_q;
  assign ld_q       = load_q;
  assign init_a     = load_q;
  assign init_count = load_q;
  assign ld_add     = add_q & q0;
  assign ld_shift   = shift_q;
  assign count_en   = shift_q;
  assign ready      = (state == IDLE);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N multiplier using an A/Q/M shift-add datapath.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus,
  output state_t                state
);

  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]  a;
  logic [N-1:0]  q;
  logic [N-1:0]  m;
  logic          c;
  logic [CW-1:0] count;
  logic          count_co;
  logic          ld_m, ld_q, init_a, init_count, ld_add, ld_shift, count_en;
  logic [N:0]    sum;
  logic [2*N:0]  shifted;

  assign count_co = (count == CW'(N - 1));
  assign sum      = {1'b0, a} + {1'b0, m};
  // Logical right shift of the whole {C,A,Q} chain; written this way so N=1 needs no special case.
  assign shifted  = {c, a, q} >> 1;

  shift_add_multiplier_controller u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (bus.START),
    .count_co   (count_co),
    .q0         (q[0]),
    .ld_m       (ld_m),
    .ld_q       (ld_q),
    .init_a     (init_a),
    .init_count (init_count),
    .ld_add     (ld_add),
    .ld_shift   (ld_shift),
    .count_en   (count_en),
    .ready      (bus.READY),
    .state      (state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a     <= '0;
      q     <= '0;
      m     <= '0;
      c     <= 1'b0;
      count <= '0;
    end else begin
      if (ld_m) m <= bus.multiplicand;
      if (ld_q) q <= bus.multiplier;
      if (init_a) begin
        a <= '0;
        c <= 1'b0;
      end else if (ld_add) begin
        {c, a} <= sum;
      end else if (ld_shift) begin
        {c, a, q} <= shifted;
      end
      if (init_count) count <= '0;
      else if (count_en) count <= count + CW'(1);
    end
  end

  assign bus.product = {a, q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (N=8): scoreboard queue plus READY-rise monitor.
module tb_shift_add_multiplier;
  import shift_add_multiplier_pkg::*;

  localparam int N   = 8;
  localparam int LAT = 2 * N + 2;  // negedges from START falling to first READY=1

  logic   clk;
  logic   rst;
  state_t dut_state;

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (dut_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_ready = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      prev_ready = 1'b1;
    end else begin
      if (bus.READY && !prev_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(bus.product), 64'hDEAD);
        end else begin
          check("product", 64'(bus.product), 64'(exp_q.pop_front()));
        end
      end
      prev_ready = bus.READY;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string name);
    int cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (bus.READY) break;
    end
    check(name, 64'(cycles), 64'(LAT));
  endtask

  task automatic run_op(input logic [N-1:0] mc, input logic [N-1:0] mp,
                        input logic [2*N-1:0] expected, input int hold);
    @(negedge clk);
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    bus.START        = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.READY), 64'd0);
      check("hold_state", 64'(dut_state), 64'(STARTING));
      check("hold_product", 64'(bus.product), 64'(last_exp));
    end
    @(negedge clk);
    bus.START = 1'b0;
    exp_q.push_back(expected);
    wait_done("latency");
    last_exp = expected;
    repeat (2) @(negedge clk);
    check("product_held", 64'(bus.product), 64'(last_exp));
  endtask

  // Hand-computed vectors: multiplicand, multiplier, product
  logic [N-1:0]   vec_m[6] = '{8'd13, 8'd255, 8'd0,   8'd1,   8'd128, 8'd7};
  logic [N-1:0]   vec_q[6] = '{8'd11, 8'd255, 8'd200, 8'd255, 8'd2,   8'd9};
  logic [2*N-1:0] vec_p[6] = '{16'h008F, 16'hFE01, 16'h0000, 16'h00FF, 16'h0100, 16'h003F};

  initial begin
    rst              = 1'b0;
    bus.START        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    last_exp         = '0;
    #1;
    check("reset_ready", 64'(bus.READY), 64'd1);
    check("reset_product", 64'(bus.product), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle after reset, no START
    repeat (5) begin
      @(negedge clk);
      check("idle_ready", 64'(bus.READY), 64'd1);
      check("idle_product", 64'(bus.product), 64'd0);
      check("idle_state", 64'(dut_state), 64'(IDLE));
    end

    // Directed products
    for (int i = 0; i < 6; i++) run_op(vec_m[i], vec_q[i], vec_p[i], 0);

    // START held high in STARTING for 10 cycles
    run_op(8'd13, 8'd11, 16'd143, 10);

    // START pulsed during the 4th ADD with new operands: ignored
    @(negedge clk);
    bus.multiplicand = 8'd7;
    bus.multiplier   = 8'd9;
    bus.START        = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    exp_q.push_back(16'd63);
    repeat (8) @(negedge clk);
    check("fourth_add_state", 64'(dut_state), 64'(ADD));
    bus.START        = 1'b1;
    bus.multiplicand = 8'd3;
    bus.multiplier   = 8'd3;
    @(negedge clk);
    bus.START = 1'b0;
    begin
      int cycles = 9;
      while (cycles < 100) begin
        @(negedge clk);
        cycles++;
        if (bus.READY) break;
      end
      check("busy_start_latency", 64'(cycles), 64'(LAT));
    end
    last_exp = 16'd63;
    repeat (20) begin
      @(negedge clk);
      check("no_second_op", 64'(bus.READY), 64'd1);
    end
    check("after_ignore_product", 64'(bus.product), 64'd63);

    // Reset during the 5th SHIFT of 200x150
    @(negedge clk);
    bus.multiplicand = 8'd200;
    bus.multiplier   = 8'd150;
    bus.START        = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (11) @(negedge clk);
    check("fifth_shift_state", 64'(dut_state), 64'(SHIFT));
    rst = 1'b0;
    #1;
    check("abort_ready", 64'(bus.READY), 64'd1);
    check("abort_product", 64'(bus.product), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    last_exp = '0;
    run_op(8'd7, 8'd9, 16'd63, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
